digit_sum_sequencer: RTL and testbench

- Synthesisable sequencer that replaces the hand-timed reset-and-wait bring-up of the single-cycle MIPS datapath.
- On start it writes NUM_DIGITS BCD digits into consecutive register-file entries, reads them back and reduces them in a selectable mode (add / xor / max).
- It writes the result to register DEST_REG and data-memory word DEST_MEM, then pulses done.
- It sits beside MipsCPU and masters the register-file write port, one register-file read port and the data-memory write port during bring-up.

---
 rtl/digit_sum_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_digit_sum_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_sum_sequencer.sv
// Bring-up sequencer: loads BCD digits into the register file, reduces them (add/xor/max), writes result to DEST_REG/DEST_MEM.
// Latency 2*NUM_DIGITS+4 cycles from the start cycle to done (2 on a rejected digit); no backpressure, start is ignored while busy.
module digit_sum_sequencer #(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 8,
    parameter int BASE_REG   = 1,
    parameter int DEST_REG   = 31,
    parameter int DEST_MEM   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op_mode,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [REG_ADDR_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,
    output logic                    dm_we,
    output logic [MEM_ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]       dm_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_W-1:0]       result
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SUM    = 3'd3;
    localparam logic [2:0] S_WB_REG = 3'd4;
    localparam logic [2:0] S_WB_MEM = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_MAX = 2'b10;

    localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [2:0]              state_q,  state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [1:0]              mode_q,   mode_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [DATA_W-1:0]       acc_q,    acc_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic                    err_q,    err_d;

    logic                    bad_digit;
    logic [3:0]              cur_digit;
    logic [DATA_W-1:0]       acc_next;
    logic [REG_ADDR_W-1:0]   idx_reg;

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    assign idx_reg   = REG_ADDR_W'(BASE_REG) + REG_ADDR_W'(idx_q);

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_q[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Reserved op code 11 falls into the add branch.
    always_comb begin
        case (mode_q)
            OP_XOR:  acc_next = acc_q ^ rf_rdata;
            OP_MAX:  acc_next = (rf_rdata > acc_q) ? rf_rdata : acc_q;
            default: acc_next = acc_q + rf_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    digits_d = digits;
                    mode_d   = op_mode;
                    result_d = '0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_digit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_SUM;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SUM: begin
                acc_d = acc_next;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_WB_REG;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WB_REG: state_d = S_WB_MEM;
            S_WB_MEM: begin
                result_d = acc_q;
                state_d  = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode straight from state so a mid-run reset zeroes them at once.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_raddr = '0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        case (state_q)
            S_LOAD: begin
                rf_we    = 1'b1;
                rf_waddr = idx_reg;
                rf_wdata = DATA_W'(cur_digit);
            end
            S_SUM: rf_raddr = idx_reg;
            S_WB_REG: begin
                rf_we    = 1'b1;
                rf_waddr = REG_ADDR_W'(DEST_REG);
                rf_wdata = acc_q;
            end
            S_WB_MEM: begin
                dm_we    = 1'b1;
                dm_addr  = MEM_ADDR_W'(DEST_MEM);
                dm_wdata = acc_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_digit_sum_sequencer.sv
// Directed bench for digit_sum_sequencer with register-file/data-memory models and an expected-result queue.
module tb_digit_sum_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Main DUT, NUM_DIGITS = 8
    logic        start;
    logic [1:0]  op_mode;
    logic [31:0] digits;
    logic        rf_we, dm_we, busy, done, err;
    logic [4:0]  rf_waddr, rf_raddr;
    logic [31:0] rf_wdata, rf_rdata, dm_wdata, result;
    logic [7:0]  dm_addr;

    // Second DUT, NUM_DIGITS = 3
    logic        start3;
    logic [1:0]  op_mode3;
    logic [11:0] digits3;
    logic        rf_we3, dm_we3, busy3, done3, err3;
    logic [4:0]  rf_waddr3, rf_raddr3;
    logic [31:0] rf_wdata3, rf_rdata3, dm_wdata3, result3;
    logic [7:0]  dm_addr3;

    digit_sum_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .op_mode(op_mode), .digits(digits),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    digit_sum_sequencer #(.NUM_DIGITS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .op_mode(op_mode3), .digits(digits3),
        .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3), .rf_raddr(rf_raddr3),
        .rf_rdata(rf_rdata3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .busy(busy3), .done(done3), .err(err3), .result(result3)
    );

    logic [31:0] rf  [0:31];
    logic [31:0] dm  [0:255];
    logic [31:0] rf3 [0:31];
    logic [31:0] dm3 [0:255];

    always @(posedge clk) begin
        if (rf_we)  rf[rf_waddr]   <= rf_wdata;
        if (dm_we)  dm[dm_addr]    <= dm_wdata;
        if (rf_we3) rf3[rf_waddr3] <= rf_wdata3;
        if (dm_we3) dm3[dm_addr3]  <= dm_wdata3;
    end
    assign rf_rdata  = rf[rf_raddr];
    assign rf_rdata3 = rf3[rf_raddr3];

    int rf_wr_cnt = 0;
    int dm_wr_cnt = 0;
    always @(posedge clk) begin
        if (rf_we) rf_wr_cnt = rf_wr_cnt + 1;
        if (dm_we) dm_wr_cnt = dm_wr_cnt + 1;
    end

    int overlap_cnt = 0;
    always @(negedge clk) begin
        if ((rf_we && dm_we) || (rf_we3 && dm_we3)) overlap_cnt = overlap_cnt + 1;
    end

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One run on the 8-digit DUT; optionally pulses start again at cycle poke_cyc while busy.
    task automatic do_run(input string tag, input logic [31:0] dig, input logic [1:0] mode,
                          input logic [31:0] exp_res, input logic exp_err, input int poke_cyc);
        int   cyc;
        int   rf0;
        int   dm0;
        int   exp_lat;
        exp_t e;
        exp_t x;
        rf0 = rf_wr_cnt;
        dm0 = dm_wr_cnt;
        exp_lat = exp_err ? 2 : 20;
        @(negedge clk);
        digits  = dig;
        op_mode = mode;
        start   = 1'b1;
        x.res = exp_res;
        x.err = exp_err;
        sb_q.push_back(x);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check({tag, ":busy"}, 128'(busy), 128'(1));
            if (done) break;
            if (cyc == poke_cyc) begin
                start   = 1'b1;
                op_mode = 2'b10;
                digits  = 32'hFFFF_FFFF;
            end
        end
        check({tag, ":latency"}, 128'(cyc), 128'(exp_lat));
        e = sb_q.pop_front();
        check({tag, ":result"}, 128'(result), 128'(e.res));
        check({tag, ":err"}, 128'(err), 128'(e.err));
        check({tag, ":rf_writes"}, 128'(rf_wr_cnt - rf0), 128'(exp_err ? 0 : 9));
        check({tag, ":dm_writes"}, 128'(dm_wr_cnt - dm0), 128'(exp_err ? 0 : 1));
        if (!exp_err) begin
            check({tag, ":reg31"}, 128'(rf[31]), 128'(exp_res));
            check({tag, ":dmem0"}, 128'(dm[0]), 128'(exp_res));
        end
        @(negedge clk);
        check({tag, ":idle"}, 128'({done, busy}), 128'(0));
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;
        int          dones;
        exp_t        e;
        exp_t        x;

        reset    = 1'b0;
        start    = 1'b0;
        op_mode  = 2'b00;
        digits   = '0;
        start3   = 1'b0;
        op_mode3 = 2'b00;
        digits3  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({rf_we, rf_waddr, rf_wdata, rf_raddr, dm_we, dm_addr,
                                     dm_wdata, busy, done, err, result}), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 128'({rf_we, rf_waddr, rf_wdata, rf_raddr, dm_we, dm_addr,
                                          dm_wdata, busy, done, err, result}), 128'(0));

        // digits 0..7 = 2,5,0,1,2,3,4,5
        d = 32'h5432_1052;
        do_run("add", d, 2'b00, 32'd22, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("load_reg%0d", i + 1), 128'(rf[i + 1]), 128'(d[4*i +: 4]));
        end
        do_run("xor", d, 2'b01, 32'd6, 1'b0, 0);
        do_run("max_poked", d, 2'b10, 32'd5, 1'b0, 7);
        do_run("add_all9", 32'h9999_9999, 2'b00, 32'd72, 1'b0, 0);
        do_run("bad_digit", 32'h5432_C052, 2'b00, 32'd0, 1'b1, 0);
        check("bad_digit:reg31_kept", 128'(rf[31]), 128'(72));

        // Reset in the middle of SUM: cycle 12 reads digit index 2 (register 3).
        @(negedge clk);
        digits  = 32'h1111_1111;
        op_mode = 2'b00;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("midrun:raddr", 128'({busy, rf_raddr}), 128'({1'b1, 5'd3}));
        reset = 1'b0;
        #1;
        check("midrun:outputs_zero", 128'({rf_we, rf_waddr, rf_wdata, rf_raddr, dm_we, dm_addr,
                                           dm_wdata, busy, done, err, result}), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("midrun:no_wb", 128'({rf[31], dm[0], busy}), 128'({32'd72, 32'd72, 1'b0}));

        // Reserved op code behaves as add: 7+8+9.
        do_run("reserved_add", 32'h0000_0987, 2'b11, 32'd24, 1'b0, 0);

        // start held for 40 cycles: accepted at cycle 0 and again in the IDLE cycle 21.
        @(negedge clk);
        digits  = 32'h9999_9999;
        op_mode = 2'b00;
        start   = 1'b1;
        x.res = 32'd72;
        x.err = 1'b0;
        sb_q.push_back(x);
        sb_q.push_back(x);
        dones = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 40) start = 1'b0;
            if (done) begin
                dones++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("held:result", 128'(result), 128'(e.res));
                end
            end
        end
        check("held:run_count", 128'(dones), 128'(2));

        // NUM_DIGITS = 3 build, digits 7,8,9.
        @(negedge clk);
        digits3  = 12'h987;
        op_mode3 = 2'b00;
        start3   = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start3 = 1'b0;
            if (done3) break;
        end
        check("n3:latency", 128'(cyc), 128'(10));
        check("n3:result", 128'({err3, result3}), 128'({1'b0, 32'd24}));
        check("n3:reg31_dmem0", 128'({rf3[31], dm3[0]}), 128'({32'd24, 32'd24}));
        check("n3:regs", 128'({rf3[1], rf3[2], rf3[3]}), 128'({32'd7, 32'd8, 32'd9}));
        @(negedge clk);
        check("n3:idle", 128'({done3, busy3}), 128'(0));

        check("we_overlap", 128'(overlap_cnt), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
